rr_arbiter_generic: RTL and testbench
=====================================

# rr_arbiter_generic

Parameterised N-way round-robin arbiter that shares one downstream resource among N requesters. It sits in front of the generic priority encoder datapath: it keeps the rotating priority pointer and holds each grant until the owner releases it. It also forces release when a hold-time limit expires, and reports the granted requester as a one-hot vector, a binary index, and a valid flag.

## Interface
- N, default 6: number of requesters; legal range N ≥ 2; need not be a power of two.
- MAX_HOLD, default 16: maximum consecutive cycles a grant may be held; legal range MAX_HOLD ≥ 2.
- W, derived, $clog2(N): width of the index output.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; overrides all other inputs.
- req  in  N  request vector; bit i high means requester i wants the resource.
- done  in  1  release strobe from the current owner; sampled only while a grant is active.
- gnt  out  N  registered one-hot grant; all zero when no grant is active.
- y  out  W  registered binary index of the granted requester; 0 when z=0.
- z  out  1  registered grant-valid flag; equals the OR of gnt.
- timeout  out  1  registered one-cycle pulse marking a forced release.

## Operation
- Internal state:
  - FSM state: IDLE or BUSY.
  - Pointer ptr, W bits, range 0..N-1.
  - Hold counter cnt, $clog2(MAX_HOLD) bits.
- Reset values: state=IDLE, ptr=0, cnt=0, gnt=0, y=0, z=0, timeout=0.
- IDLE behaviour:
  - timeout is cleared every IDLE cycle unless that cycle is the first IDLE cycle after a forced release.
  - If req≠0, the winner is the first set bit found by a circular search that starts at ptr and runs ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On that edge: gnt gets the winner's one-hot, y gets the winner index, z=1, cnt=0, and the FSM moves to BUSY.
  - If req=0, the FSM stays in IDLE and the outputs stay zero.
- BUSY behaviour; the grant is held and ptr is frozen. A release occurs on the first edge where any of the following holds:
  - done=1 (normal release);
  - req[y]=0 (owner withdrew; treated as a normal release);
  - cnt=MAX_HOLD-1 with neither of the above (forced release).
- Without a release, cnt increments by 1 each cycle.
- On a release edge:
  - gnt=0, y=0, z=0, and the FSM moves to IDLE.
  - ptr takes y+1, wrapping N-1 to 0; the wrap is explicit and does not rely on W-bit overflow when N is not a power of two.
  - On a forced release only, timeout=1.
- When a normal release condition and the MAX_HOLD limit coincide, the release counts as normal and timeout stays 0.
- Index values ≥ N never appear on y. Inputs on req bits for the current owner's neighbours have no effect during BUSY.
- Reset mid-operation: asserting rst in BUSY clears every output and ptr on that edge, with no timeout pulse. The first arbitration after reset starts from requester 0.

## Timing
- Grant latency: req sampled in IDLE on edge k produces gnt/y/z valid after edge k.
- Hold length:
  - Normal: the grant stays valid from its first cycle until the edge that samples done=1 or req[y]=0.
  - Forced: the grant is visible for exactly MAX_HOLD cycles.
- Turnaround: every release is followed by exactly one cycle with z=0 before the next grant. Back-to-back grants are therefore spaced at least one idle cycle apart.
- timeout is high only during that turnaround cycle.
- Throughput with all requesters active and immediate done: one grant every 2 cycles, served in strict rotation.
- done sampled while z=0 is ignored.

## Test plan
- Reset and single request: assert rst for 2 cycles, then req=6'b000001 → the cycle after the edge shows gnt=000001, y=0, z=1. Then done=1 for one cycle → gnt=0, z=0, and ptr=1.
- Full rotation: req=6'b111111 held, done pulsed on the first cycle of each grant → y sequence 0,1,2,3,4,5,0, with z=0 for one cycle between grants and timeout never set.
- Wrap-around and skipping: after requester 5 is granted and released, apply req=6'b100001 → y=0 granted next. Then with ptr=1 and req=6'b001001 → y=3, skipping idle bits 1 and 2.
- Forced release: MAX_HOLD=16, req=6'b000100 held, done=0 → gnt=000100 for exactly 16 cycles, then one cycle with z=0 and timeout=1 and ptr=3. Requester 2 is then regranted, since it is the only requester.
- Withdrawal and coincidence:
  - The owner drops its req bit at cycle 5 of a hold → release on that edge with timeout=0.
  - done=1 arrives on the cycle where cnt=MAX_HOLD-1 → timeout stays 0.
- Reset mid-grant: assert rst while y=4 and z=1 → next cycle gnt=0, y=0, z=0, timeout=0. With req=6'b111111 afterwards, the first grant goes to y=0.

Source files
------------

// File: rtl/rr_arbiter_generic.sv
// N-way round-robin arbiter with grant hold, owner release and a hold-time limit.
// Grant is reported as one-hot, binary index and valid flag, all registered.
module rr_arbiter_generic #(
    parameter  int N        = 6,
    parameter  int MAX_HOLD = 16,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [W-1:0] y,
    output logic         z,
    output logic         timeout
);
    localparam int             CW       = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_HOLD - 1);
    localparam logic [W-1:0]   LAST_IDX = W'(N - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [W-1:0]  y_reg, y_next;
    logic          z_reg, z_next;
    logic          timeout_reg, timeout_next;

    logic [W-1:0]  cand_idx [N];
    logic [N-1:0]  cand_hit;
    logic [W-1:0]  win_idx;
    logic          release_normal;
    logic          release_forced;

    // Candidate gi is the requester gi steps after ptr, wrapped explicitly
    // so that non-power-of-two N never yields an index >= N.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [W:0] sum;
            assign sum          = {1'b0, ptr_reg} + (W+1)'(gi);
            assign cand_idx[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest candidate offset wins: scan downward so the last hit written sticks.
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                win_idx = cand_idx[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            gnt_reg     <= '0;
            y_reg       <= '0;
            z_reg       <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            y_reg       <= y_next;
            z_reg       <= z_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        gnt_next       = gnt_reg;
        y_next         = y_reg;
        z_next         = z_reg;
        timeout_next   = 1'b0;
        release_normal = done || !req[y_reg];
        release_forced = !release_normal && (cnt_reg == CNT_LAST);
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = BUSY;
                    gnt_next   = N'(1) << win_idx;
                    y_next     = win_idx;
                    z_next     = 1'b1;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (release_normal || release_forced) begin
                    state_next   = IDLE;
                    gnt_next     = '0;
                    y_next       = '0;
                    z_next       = 1'b0;
                    cnt_next     = '0;
                    ptr_next     = (y_reg == LAST_IDX) ? '0 : y_reg + 1'b1;
                    timeout_next = release_forced;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt     = gnt_reg;
        y       = y_reg;
        z       = z_reg;
        timeout = timeout_reg;
    end

endmodule

// File: tb/tb_rr_arbiter_generic.sv
// Scoreboard bench for rr_arbiter_generic: a behavioural model queues the
// expected outputs per edge; directed checks cover the rotation and hold limits.
module tb_rr_arbiter_generic;
    localparam int N        = 6;
    localparam int MAX_HOLD = 16;
    localparam int W        = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] gnt;
    logic [W-1:0] y;
    logic         z;
    logic         timeout;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    int m_busy = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    int m_y    = 0;
    int m_to   = 0;

    rr_arbiter_generic #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .y(y), .z(z), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic dn);
        int k;
        int found;
        if (r) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_y = 0; m_to = 0;
        end else if (m_busy == 0) begin
            m_to  = 0;
            found = 0;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (found == 0 && rq[k]) begin
                    found = 1; m_busy = 1; m_y = k; m_cnt = 0;
                end
            end
        end else if (dn || !rq[m_y]) begin
            m_busy = 0; m_ptr = (m_y + 1) % N; m_y = 0; m_to = 0;
        end else if (m_cnt == MAX_HOLD - 1) begin
            m_busy = 0; m_ptr = (m_y + 1) % N; m_y = 0; m_to = 1;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic int model_pack();
        int g;
        g = (m_busy != 0) ? (1 << m_y) : 0;
        return (m_to << (N + W + 1)) | (m_busy << (N + W)) | (m_y << N) | g;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] rq, input logic dn);
        int obs;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        model_edge(r, rq, dn);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        obs = int'({timeout, z, y, gnt});
        if (exp_q.size() == 0) check_eq("sb_underflow", 0, 1);
        else check_eq("outputs", obs, exp_q.pop_front());
        $display("t=%0t rst=%0b req=%b done=%0b -> gnt=%b y=%0d z=%0b timeout=%0b",
                 $time, r, rq, dn, gnt, y, z, timeout);
    endtask

    initial begin
        int zc;
        int rot_exp[6] = '{0, 1, 2, 3, 4, 5};

        // Reset, single request, release
        step(1'b1, 6'b000000, 1'b0);
        step(1'b1, 6'b000000, 1'b0);
        check_eq("rst_outputs", int'({timeout, z, y, gnt}), 0);
        step(1'b0, 6'b000001, 1'b0);
        check_eq("single_gnt", int'(gnt), 1);
        step(1'b0, 6'b000001, 1'b1);
        check_eq("single_release_z", int'(z), 0);
        step(1'b0, 6'b000011, 1'b0);
        check_eq("ptr_after_release", int'(y), 1);
        step(1'b0, 6'b000011, 1'b1);

        // Full rotation with done held high: done is ignored while idle
        step(1'b1, 6'b000000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 6'b111111, 1'b1);
            check_eq("rot_y", int'(y), rot_exp[i]);
            step(1'b0, 6'b111111, 1'b1);
            check_eq("rot_gap_z", int'(z), 0);
        end

        // Wrap-around, then skipping idle requesters
        step(1'b0, 6'b100001, 1'b0);
        check_eq("wrap_y", int'(y), 0);
        step(1'b0, 6'b100001, 1'b1);
        step(1'b0, 6'b001001, 1'b0);
        check_eq("skip_y", int'(y), 3);
        step(1'b0, 6'b001001, 1'b1);

        // Forced release after MAX_HOLD cycles
        zc = 0;
        step(1'b0, 6'b000100, 1'b0);
        check_eq("forced_y", int'(y), 2);
        zc += int'(z);
        for (int i = 0; i < MAX_HOLD; i++) begin
            step(1'b0, 6'b000100, 1'b0);
            zc += int'(z);
        end
        check_eq("forced_hold_len", zc, MAX_HOLD);
        check_eq("forced_timeout", int'(timeout), 1);
        step(1'b0, 6'b000100, 1'b0);
        check_eq("regrant_y", int'(y), 2);
        check_eq("regrant_timeout", int'(timeout), 0);

        // Owner withdraws at cycle 5 of the hold
        for (int i = 0; i < 3; i++) step(1'b0, 6'b000100, 1'b0);
        step(1'b0, 6'b000000, 1'b0);
        check_eq("withdraw_z", int'(z), 0);
        check_eq("withdraw_timeout", int'(timeout), 0);

        // done coincides with the hold limit
        step(1'b0, 6'b000100, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(1'b0, 6'b000100, 1'b0);
        check_eq("coincide_still_held", int'(z), 1);
        step(1'b0, 6'b000100, 1'b1);
        check_eq("coincide_timeout", int'(timeout), 0);
        check_eq("coincide_z", int'(z), 0);

        // Reset during a grant
        step(1'b0, 6'b010000, 1'b0);
        check_eq("pre_rst_y", int'(y), 4);
        step(1'b1, 6'b111111, 1'b0);
        check_eq("mid_rst_outputs", int'({timeout, z, y, gnt}), 0);
        step(1'b0, 6'b111111, 1'b0);
        check_eq("post_rst_y", int'(y), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 (($urandom_range(0, 3) == 0) ? 6'b111111 : N'($urandom_range(0, 63))),
                 ($urandom_range(0, 7) == 0));
        end

        check_eq("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
